// File: rtl/stage_link.sv
// Elastic link between two pipeline stages: a circular buffer with optional
// zero-latency bypass, synchronous flush and a saturating delivery counter.
module stage_link #(
    parameter int BUS_WIDTH = 64,
    parameter int DEPTH     = 2,
    parameter int BYPASS    = 0,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [BUS_WIDTH-1:0]         in_bus,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [BUS_WIDTH-1:0]         out_bus,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [CNT_WIDTH-1:0]         xfer_cnt
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CW-1:0]        count_nxt;
    logic                 accept;
    logic                 deliver;
    logic                 pass_thru;
    logic                 do_write;
    logic                 do_read;
    logic                 empty;
    logic                 full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [1:0] occupancy(input logic [CW-1:0] c);
        if (c == '0)
            return ST_EMPTY;
        else if (c == FULL_CNT)
            return ST_FULL;
        else
            return ST_PARTIAL;
    endfunction

    assign empty = (state == ST_EMPTY);
    assign full  = (state == ST_FULL);

    // Ready depends only on registered occupancy, never on out_ready.
    assign in_ready = !full && !flush && rst;

    always_comb begin
        if (BYPASS != 0 && empty) begin
            out_valid = in_valid && !flush && rst;
            out_bus   = in_bus;
        end else begin
            out_valid = !empty && !flush;
            out_bus   = mem[rd_ptr];
        end
    end

    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    // An item that passes straight through never touches storage.
    assign pass_thru = (BYPASS != 0) && empty && accept && deliver;
    assign do_write  = accept && !pass_thru;
    assign do_read   = deliver && !pass_thru;

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_write && !do_read)
            count_nxt = count + 1'b1;
        else if (do_read && !do_write)
            count_nxt = count - 1'b1;
        state_nxt = occupancy(count_nxt);
    end

    // Control state: occupancy, pointers and delivery counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count    <= '0;
            state    <= ST_EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            xfer_cnt <= '0;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_write)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (do_read)
                    rd_ptr <= ptr_inc(rd_ptr);
            end
            if (deliver)
                xfer_cnt <= sat_inc(xfer_cnt);
        end
    end

    // Storage: cleared on reset so a registered link shows zero while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (do_write) begin
            mem[wr_ptr] <= in_bus;
        end
    end

endmodule

// File: tb/tb_stage_link.sv
// Bench for stage_link: directed checks on a two-entry registered link and
// randomized traffic on bypass and registered three-entry links.
module tb_stage_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // u0: DEPTH=2, BYPASS=0, CNT_WIDTH=3
    logic        rst0, flush0, in_valid0, out_ready0, in_ready0, out_valid0;
    logic [15:0] in_bus0, out_bus0;
    logic [1:0]  count0;
    logic [2:0]  xfer0;

    // u1: DEPTH=3, BYPASS=1; u2: DEPTH=3, BYPASS=0; shared inputs
    logic        rst1, flush1, in_valid1, out_ready1;
    logic [15:0] in_bus1;
    logic        in_ready1, out_valid1, in_ready2, out_valid2;
    logic [15:0] out_bus1, out_bus2;
    logic [1:0]  count1, count2;
    logic [31:0] xfer1, xfer2;

    stage_link #(.BUS_WIDTH(16), .DEPTH(2), .BYPASS(0), .CNT_WIDTH(3)) u0 (
        .clk(clk), .rst(rst0), .flush(flush0), .in_bus(in_bus0), .in_valid(in_valid0),
        .in_ready(in_ready0), .out_bus(out_bus0), .out_valid(out_valid0),
        .out_ready(out_ready0), .count(count0), .xfer_cnt(xfer0));

    stage_link #(.BUS_WIDTH(16), .DEPTH(3), .BYPASS(1), .CNT_WIDTH(32)) u1 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_bus(in_bus1), .in_valid(in_valid1),
        .in_ready(in_ready1), .out_bus(out_bus1), .out_valid(out_valid1),
        .out_ready(out_ready1), .count(count1), .xfer_cnt(xfer1));

    stage_link #(.BUS_WIDTH(16), .DEPTH(3), .BYPASS(0), .CNT_WIDTH(32)) u2 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_bus(in_bus1), .in_valid(in_valid1),
        .in_ready(in_ready2), .out_bus(out_bus2), .out_valid(out_valid2),
        .out_ready(out_ready1), .count(count2), .xfer_cnt(xfer2));

    int nchk = 0;
    int nerr = 0;

    // Reference model for u1 (index 0, bypass) and u2 (index 1): an ordered list.
    logic [15:0] md [2][3];
    int          msz [2];
    int          mxf [2];
    logic        last_acc1;
    logic [15:0] log1 [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of shared traffic on u1/u2, checked against the model.
    task automatic cyc(input logic iv, input logic [15:0] ib, input logic ordy, input logic fl);
        logic        ev [2];
        logic        er [2];
        logic [15:0] eb [2];
        logic        ov, orr;
        logic [15:0] ob;
        logic [1:0]  oc;
        logic [31:0] ox;
        in_valid1 = iv; in_bus1 = ib; out_ready1 = ordy; flush1 = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            er[k] = (msz[k] < 3) && !fl;
            if (k == 0 && msz[k] == 0) begin
                ev[k] = iv && !fl;
                eb[k] = ib;
            end else begin
                ev[k] = (msz[k] != 0) && !fl;
                eb[k] = md[k][0];
            end
            orr = (k == 0) ? in_ready1  : in_ready2;
            ov  = (k == 0) ? out_valid1 : out_valid2;
            ob  = (k == 0) ? out_bus1   : out_bus2;
            oc  = (k == 0) ? count1     : count2;
            ox  = (k == 0) ? xfer1      : xfer2;
            chk((k == 0) ? "u1_in_ready" : "u2_in_ready", {31'd0, orr}, {31'd0, er[k]});
            chk((k == 0) ? "u1_out_valid" : "u2_out_valid", {31'd0, ov}, {31'd0, ev[k]});
            if (ev[k])
                chk((k == 0) ? "u1_out_bus" : "u2_out_bus", {16'd0, ob}, {16'd0, eb[k]});
            chk((k == 0) ? "u1_count" : "u2_count", {30'd0, oc}, msz[k]);
            chk((k == 0) ? "u1_xfer" : "u2_xfer", ox, mxf[k]);
        end
        last_acc1 = iv && er[0];
        if (ev[0] && ordy)
            log1.push_back(out_bus1);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            logic acc, del;
            acc = iv && er[k];
            del = ev[k] && ordy;
            if (fl) begin
                msz[k] = 0;
            end else if (!(k == 0 && msz[k] == 0 && acc && del)) begin
                if (del) begin
                    for (int j = 0; j < 2; j++) md[k][j] = md[k][j+1];
                    msz[k]--;
                end
                if (acc) begin
                    md[k][msz[k]] = ib;
                    msz[k]++;
                end
            end
            if (del) mxf[k]++;
        end
        #1;
    endtask

    initial begin
        rst0 = 1'b0; flush0 = 1'b0; in_valid0 = 1'b1; out_ready0 = 1'b1; in_bus0 = 16'h1234;
        rst1 = 1'b0; flush1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1; in_bus1 = 16'h4321;
        for (int k = 0; k < 2; k++) begin msz[k] = 0; mxf[k] = 0; end
        #12;
        chk("rst_count0", {30'd0, count0}, 0);
        chk("rst_in_ready0", {31'd0, in_ready0}, 0);
        chk("rst_out_valid0", {31'd0, out_valid0}, 0);
        chk("rst_out_bus0", {16'd0, out_bus0}, 0);
        chk("rst_xfer0", {29'd0, xfer0}, 0);
        chk("rst_out_valid1", {31'd0, out_valid1}, 0);
        chk("rst_in_ready1", {31'd0, in_ready1}, 0);
        chk("rst_out_bus2", {16'd0, out_bus2}, 0);
        in_valid0 = 1'b0; out_ready0 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
        #1 rst0 = 1'b1; rst1 = 1'b1;
        tick();
        chk("post_rst_in_ready0", {31'd0, in_ready0}, 1);

        // Fill the two-entry link, then drain it in order.
        in_valid0 = 1'b1; in_bus0 = 16'h1;
        tick();
        in_bus0 = 16'h2; #1;
        chk("fill1_count", {30'd0, count0}, 1);
        chk("fill1_out_bus", {16'd0, out_bus0}, 16'h1);
        chk("fill1_out_valid", {31'd0, out_valid0}, 1);
        tick();
        in_bus0 = 16'h3; out_ready0 = 1'b1; #1;
        chk("full_count", {30'd0, count0}, 2);
        chk("full_in_ready", {31'd0, in_ready0}, 0);
        chk("drain_head", {16'd0, out_bus0}, 16'h1);
        tick();
        in_valid0 = 1'b0; #1;
        chk("drain_second", {16'd0, out_bus0}, 16'h2);
        chk("freed_in_ready", {31'd0, in_ready0}, 1);
        chk("drain_xfer1", {29'd0, xfer0}, 1);
        tick();
        chk("drained_count", {30'd0, count0}, 0);
        chk("drained_valid", {31'd0, out_valid0}, 0);
        chk("drain_xfer2", {29'd0, xfer0}, 2);

        // Flush wins over a simultaneous accept and deliver.
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_bus0 = 16'h5;
        tick();
        in_bus0 = 16'h6;
        tick();
        chk("pre_flush_count", {30'd0, count0}, 2);
        flush0 = 1'b1; in_bus0 = 16'h7; out_ready0 = 1'b1; #1;
        chk("flush_in_ready", {31'd0, in_ready0}, 0);
        chk("flush_out_valid", {31'd0, out_valid0}, 0);
        tick();
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; #1;
        chk("post_flush_count", {30'd0, count0}, 0);
        chk("post_flush_valid", {31'd0, out_valid0}, 0);
        chk("post_flush_xfer", {29'd0, xfer0}, 2);
        in_valid0 = 1'b1; in_bus0 = 16'h8;
        tick();
        in_valid0 = 1'b0; #1;
        chk("post_flush_item", {16'd0, out_bus0}, 16'h8);

        // Stream enough deliveries to saturate the 3-bit counter.
        out_ready0 = 1'b1; in_valid0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_bus0 = 16'(16'h20 + i);
            tick();
        end
        in_valid0 = 1'b0;
        tick(); tick();
        chk("sat_xfer", {29'd0, xfer0}, 7);
        chk("sat_count", {30'd0, count0}, 0);

        // Asynchronous reset between edges with one entry held.
        out_ready0 = 1'b0; in_valid0 = 1'b1; in_bus0 = 16'h99;
        tick();
        in_valid0 = 1'b0;
        chk("pre_arst_count", {30'd0, count0}, 1);
        #2 rst0 = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid0}, 0);
        chk("arst_count", {30'd0, count0}, 0);
        chk("arst_xfer", {29'd0, xfer0}, 0);
        chk("arst_in_ready", {31'd0, in_ready0}, 0);
        #1 rst0 = 1'b1;
        tick();
        chk("arst_rel_in_ready", {31'd0, in_ready0}, 1);
        in_valid0 = 1'b1; in_bus0 = 16'h55; #1;
        chk("arst_push_lat0", {31'd0, out_valid0}, 0);
        tick();
        in_valid0 = 1'b0; #1;
        chk("arst_push_valid", {31'd0, out_valid0}, 1);
        chk("arst_push_bus", {16'd0, out_bus0}, 16'h55);

        // Bypass on an empty link: same-cycle delivery, nothing stored.
        in_valid1 = 1'b1; in_bus1 = 16'hABCD; out_ready1 = 1'b1; #1;
        chk("byp_out_valid", {31'd0, out_valid1}, 1);
        chk("byp_out_bus", {16'd0, out_bus1}, 16'hABCD);
        chk("byp_count", {30'd0, count1}, 0);
        cyc(1'b1, 16'hABCD, 1'b1, 1'b0);
        chk("byp_count_after", {30'd0, count1}, 0);
        chk("byp_xfer", xfer1, 1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        log1.delete();

        // Ten items with random downstream stalls, across pointer wrap.
        begin
            int n = 0;
            int t = 0;
            while ((n < 10 || msz[0] != 0) && t < 200) begin
                cyc(n < 10, 16'(n), ($urandom_range(0, 3) != 0), 1'b0);
                if (n < 10 && last_acc1) n++;
                t++;
            end
            chk("stream_len", log1.size(), 10);
            for (int i = 0; i < 10 && i < log1.size(); i++)
                chk("stream_order", {16'd0, log1[i]}, i);
            chk("stream_xfer", xfer1, 11);
        end

        // Random traffic including occasional flushes.
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 19) == 0));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
